// File: rtl/parity_reg_arbiter_if.sv
// ----------------------------------------------------------------------------
// parity_reg_arbiter_if
// Request/response bundle between NREQ byte producers and the shared parity
// register arbiter.
//   req        : per-requester request level            (master -> slave)
//   req_data   : packed bytes, requester i at [i*DW +: DW] (master -> slave)
//   rsp_ready  : response consumer accepts               (master -> slave)
//   gnt        : one-hot, one-cycle grant pulse          (slave -> master)
//   rsp_valid  : response available                     (slave -> master)
//   rsp_id     : index of the requester whose byte is held (slave -> master)
//   rsp_q      : shared register contents                (slave -> master)
//   rsp_parity : XOR of rsp_q, 1 = odd number of ones    (slave -> master)
//   busy       : arbiter FSM not idle                    (slave -> master)
// ----------------------------------------------------------------------------
interface parity_reg_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8
);
    localparam int unsigned ID_W = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic               rsp_ready;
    logic [NREQ-1:0]    gnt;
    logic               rsp_valid;
    logic [ID_W-1:0]    rsp_id;
    logic [DW-1:0]      rsp_q;
    logic               rsp_parity;
    logic               busy;

    // Requesters plus response consumer
    modport master (
        output req, req_data, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_q, rsp_parity, busy
    );

    // Arbiter side
    modport slave (
        input  req, req_data, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_q, rsp_parity, busy
    );
endinterface

// File: rtl/parity_reg_arbiter.sv
// ----------------------------------------------------------------------------
// parity_reg_arbiter
// Shares one DW-bit enable-loaded register with an XOR-reduce parity output
// between NREQ requesters. An arbiter picks one requester, loads its byte,
// and returns the byte, its parity and the requester ID over a valid/ready
// response channel. A transaction takes at least two cycles (grant cycle,
// then one IDLE cycle); there is no IDLE bypass.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : parity_reg_arbiter_if.slave (req/req_data/rsp_ready in,
//           gnt/rsp_valid/rsp_id/rsp_q/rsp_parity/busy out)
//
// Build option:
//   PARITY_ARB_FIXED_PRIO_EN defined   -> fixed priority, lowest index wins,
//                                         no round-robin pointer.
//   PARITY_ARB_FIXED_PRIO_EN undefined -> round-robin starting at rr_ptr.
// ----------------------------------------------------------------------------
module parity_reg_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8
) (
    input  logic                clk,
    input  logic                reset,
    parity_reg_arbiter_if.slave bus
);
    localparam int unsigned ID_W = $clog2(NREQ);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            busy_q, busy_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [DW-1:0]   data_q, data_d;
    logic [ID_W-1:0] win;

    // Unpack the request bytes so the winner can index them directly
    logic [DW-1:0] req_byte [NREQ];
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_byte[g] = bus.req_data[g*DW +: DW];
    end

`ifdef PARITY_ARB_FIXED_PRIO_EN
    // Lowest asserted index wins; scanning downward leaves the lowest last
    always_comb begin : fixed_prio
        win = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                win = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    // First asserted request at or after rr_ptr, searching upward with wrap
    always_comb begin : rr_search
        int unsigned idx;
        logic        found;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(rr_ptr_q) + i) % NREQ;
            if (!found && bus.req[idx]) begin
                win   = ID_W'(idx);
                found = 1'b1;
            end
        end
    end

    // Pointer moves to the slot just past the winner on every grant
    always_comb begin : rr_update
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE && (|bus.req)) begin
            rr_ptr_d = (win == ID_W'(NREQ - 1)) ? '0 : win + ID_W'(1);
        end
    end
`endif

    // Next-state and registered-output logic
    always_comb begin : fsm_next
        state_d     = state_q;
        gnt_d       = '0;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
        rsp_id_d    = rsp_id_q;
        data_d      = data_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d     = RESP;
                    gnt_d[win]  = 1'b1;
                    rsp_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    rsp_id_d    = win;
                    data_d      = req_byte[win];
                end
            end
            RESP: begin
                // Requests are ignored here; outputs hold until accepted
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_id_q    <= '0;
            data_q      <= '0;
`ifndef PARITY_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            rsp_id_q    <= rsp_id_d;
            data_q      <= data_d;
`ifndef PARITY_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.busy       = busy_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_q      = data_q;
    // Parity follows the held register, so it is stable with rsp_q
    assign bus.rsp_parity = ^data_q;

endmodule

// File: doc/parity_reg_arbiter.md
Name: parity_reg_arbiter

Overview:
- Shares one 8-bit enable-loaded register with XOR-reduction (parity) output between NREQ requesters.
- A round-robin arbiter picks one requester, loads its byte into the register, and returns the stored byte plus its parity, tagged with the requester ID, over a valid/ready response channel.
- Sits between the per-lane byte producers and the shared parity register datapath.

Parameters:
- NREQ, 4, number of requesters; legal range 2..16.
- DW, 8, data width of each request and of the shared register.
- ID_W, $clog2(NREQ), width of the requester ID (derived; not to be overridden).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request level.
- req_data  input  NREQ*DW  packed request bytes; requester i uses bits [i*DW +: DW].
- gnt  output  NREQ  one-hot grant pulse, one cycle.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  ID_W  index of the requester whose byte is held.
- rsp_q  output  DW  shared register contents.
- rsp_parity  output  1  XOR of all rsp_q bits; 1 means an odd number of ones.
- busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, rr_ptr=0, gnt=0, rsp_valid=0, rsp_id=0, rsp_q=0, rsp_parity=0, busy=0.
  - Reset asserted mid-transaction drops the pending response without a handshake.
- FSM states: IDLE, RESP.
- IDLE:
  - If req==0, remain in IDLE.
  - Otherwise select the winner w as the first asserted req at or after rr_ptr, searching upward with wrap-around.
  - At the next edge:
    - register <= req_data[w]; rsp_id <= w; gnt <= one-hot(w); rr_ptr <= (w+1) mod NREQ; state <= RESP.
- RESP:
  - rsp_valid=1 and busy=1.
  - gnt is high only in the first RESP cycle; it is registered, so it appears one cycle after req was sampled.
  - rsp_q, rsp_id and rsp_parity stay stable while rsp_valid=1 and rsp_ready=0.
  - req is ignored in RESP.
  - If rsp_ready=1, the next edge sets state <= IDLE and rsp_valid <= 0.
- Latency and throughput:
  - Request sampled at edge N; gnt and rsp_valid high after edge N.
  - Minimum 2 cycles per transaction, with rsp_ready tied high.
- Requester rule:
  - Hold req and data stable until gnt is seen.
  - A req still high when the FSM returns to IDLE is treated as a new request.
  - A req dropped before grant is simply not considered.
- Parity:
  - rsp_parity is the combinational XOR-reduce of the register.
  - The register holds its value across IDLE; it is loaded only on a grant.
- rr_ptr wrap-around:
  - A grant to index NREQ-1 sets rr_ptr=0.
  - A single requester that holds req continuously is granted every transaction.
- Simultaneous events:
  - A rsp_ready handshake and a new req in the same cycle: the new req is arbitrated in the following IDLE cycle; there is no IDLE bypass.
  - rsp_ready while in IDLE is ignored.

Optional Feature:
- Macro: PARITY_ARB_FIXED_PRIO_EN.
- Defined:
  - Fixed priority; the lowest asserted index wins.
  - rr_ptr logic is removed.
- Undefined (default):
  - Round-robin arbitration as described in Behaviour.

Test Plan:
- Reset mid-RESP:
  - Stimulus: assert reset while rsp_valid=1.
  - Required response: all outputs 0 immediately, with no clock edge needed; after release, the FSM returns to IDLE.
- Single requester:
  - Stimulus: req=0001, data0=8'b01110001, rsp_ready=1.
  - Required response: gnt=0001 for one cycle; rsp_q=0x71, rsp_id=0, rsp_parity=0.
- Odd parity:
  - Stimulus: req=0100, data2=8'b11000001.
  - Required response: rsp_q=0xC1, rsp_id=2, rsp_parity=1.
- Round robin:
  - Stimulus: req=1111 held continuously, with data0..3 = 0x71, 0x11, 0x77, 0xC1.
  - Required response: grants in order 0,1,2,3,0; parities 0,0,0,1.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles after grant, with req=0010 asserted meanwhile.
  - Required response: rsp_q and rsp_id stable, no second gnt; the grant to requester 1 follows one IDLE cycle after the handshake.
- Wrap and skip:
  - Stimulus: rr_ptr=3 after a grant to 2, then req=0011.
  - Required response: grant to 0 (wrap), then grant to 1.
  - With PARITY_ARB_FIXED_PRIO_EN defined and req=1010: always grant 1.
